// File: rtl/elevator_request_scheduler_if.sv
// Call/floor bundle between the call buttons, the floor FSM and the LOOK request scheduler.
// The master side drives the tick, calls and present floor; the slave (scheduler) side drives the destination and status.
interface elevator_request_scheduler_if #(
    parameter int NUM_FLOORS = 4
);
    logic                  tick;
    logic [NUM_FLOORS-1:0] call_req;
    logic [NUM_FLOORS-1:0] cur_floor;
    logic [NUM_FLOORS-1:0] target_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  dir_down;
    logic                  door_open;
    logic                  fault;

    modport master (
        output tick, call_req, cur_floor,
        input  target_floor, pending, dir_up, dir_down, door_open, fault
    );

    modport slave (
        input  tick, call_req, cur_floor,
        output target_floor, pending, dir_up, dir_down, door_open, fault
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// LOOK scheduler: latches floor calls, steers target_floor, times door dwell.
// Latency: call->pending 1 clk, state->target 1 clk; no backpressure, calls are sticky until served.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS  = 4,
    parameter int DWELL_TICKS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    elevator_request_scheduler_if.slave   bus
);
    localparam int NF = NUM_FLOORS;
    localparam int CW = $clog2(DWELL_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DWELL     = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [NF-1:0] r_pending;
    logic [NF-1:0] r_target;
    logic          r_dir_up;
    logic          r_dir_down;
    logic          r_door_open;
    logic          r_fault;
    logic [CW-1:0] r_dwell_cnt;

    logic [NF-1:0] w_above_msk;
    logic [NF-1:0] w_below_msk;
    logic [NF-1:0] w_above;
    logic [NF-1:0] w_below;
    logic [NF-1:0] w_here;
    logic [NF-1:0] w_up_tgt;
    logic [NF-1:0] w_dn_tgt;
    logic          w_valid;
    logic          w_has_above;
    logic          w_has_below;
    logic          w_has_here;
    logic          w_here_call;
    logic          w_dwell_done;
    logic [CW-1:0] w_cnt_inc;

    logic [NF-1:0] w_pending_nxt;
    logic [NF-1:0] w_target_nxt;
    logic [CW-1:0] w_dwell_cnt_nxt;
    logic          w_dir_up_nxt;
    logic          w_dir_down_nxt;
    logic          w_door_nxt;

    assign w_valid = $onehot(bus.cur_floor);

    // Floors strictly above / below the car, derived from the one-hot position.
    always_comb begin
        w_above_msk = '0;
        w_below_msk = '0;
        for (int i = 0; i < NF; i++) begin
            for (int j = 0; j < NF; j++) begin
                if (j < i && bus.cur_floor[j]) w_above_msk[i] = 1'b1;
                if (j > i && bus.cur_floor[j]) w_below_msk[i] = 1'b1;
            end
        end
    end

    assign w_above     = r_pending & w_above_msk;
    assign w_below     = r_pending & w_below_msk;
    assign w_here      = r_pending & bus.cur_floor;
    assign w_has_above = |w_above;
    assign w_has_below = |w_below;
    assign w_has_here  = |w_here;

    // Nearest call above is the lowest set bit; nearest below is the highest set bit.
    always_comb begin
        w_up_tgt = '0;
        w_dn_tgt = '0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (w_above[i]) begin
                w_up_tgt    = '0;
                w_up_tgt[i] = 1'b1;
            end
        end
        for (int i = 0; i < NF; i++) begin
            if (w_below[i]) begin
                w_dn_tgt    = '0;
                w_dn_tgt[i] = 1'b1;
            end
        end
    end

    assign w_here_call  = (r_state == S_DWELL) && (|(bus.call_req & bus.cur_floor));
    assign w_cnt_inc    = r_dwell_cnt + CW'(1);
    assign w_dwell_done = (r_state == S_DWELL) && !w_here_call && bus.tick &&
                          (w_cnt_inc == CW'(DWELL_TICKS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_valid) begin
            case (r_state)
                S_IDLE: begin
                    if      (w_has_here)  w_state_nxt = S_DWELL;
                    else if (w_has_above) w_state_nxt = S_MOVE_UP;
                    else if (w_has_below) w_state_nxt = S_MOVE_DOWN;
                end
                S_MOVE_UP: begin
                    if      (w_has_here)   w_state_nxt = S_DWELL;
                    else if (!w_has_above) w_state_nxt = w_has_below ? S_MOVE_DOWN : S_IDLE;
                end
                S_MOVE_DOWN: begin
                    if      (w_has_here)   w_state_nxt = S_DWELL;
                    else if (!w_has_below) w_state_nxt = w_has_above ? S_MOVE_UP : S_IDLE;
                end
                S_DWELL: begin
                    if (w_dwell_done) begin
                        if (r_dir_down)
                            w_state_nxt = w_has_below ? S_MOVE_DOWN :
                                          (w_has_above ? S_MOVE_UP : S_IDLE);
                        else
                            w_state_nxt = w_has_above ? S_MOVE_UP :
                                          (w_has_below ? S_MOVE_DOWN : S_IDLE);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pending_nxt   = r_pending | bus.call_req;
        w_target_nxt    = r_target;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_dir_up_nxt    = r_dir_up;
        w_dir_down_nxt  = r_dir_down;
        w_door_nxt      = (w_state_nxt == S_DWELL);

        if (w_valid) begin
            // Calls for the floor being served are consumed on entry and ignored during dwell.
            if (r_state == S_DWELL || w_state_nxt == S_DWELL)
                w_pending_nxt = w_pending_nxt & ~bus.cur_floor;

            case (r_state)
                S_MOVE_UP:   w_target_nxt = w_has_above ? w_up_tgt : bus.cur_floor;
                S_MOVE_DOWN: w_target_nxt = w_has_below ? w_dn_tgt : bus.cur_floor;
                default:     w_target_nxt = bus.cur_floor;
            endcase

            if (r_state != S_DWELL)      w_dwell_cnt_nxt = '0;
            else if (w_here_call)        w_dwell_cnt_nxt = '0;
            else if (w_dwell_done)       w_dwell_cnt_nxt = '0;
            else if (bus.tick)           w_dwell_cnt_nxt = w_cnt_inc;

            case (w_state_nxt)
                S_MOVE_UP:   begin w_dir_up_nxt = 1'b1; w_dir_down_nxt = 1'b0; end
                S_MOVE_DOWN: begin w_dir_up_nxt = 1'b0; w_dir_down_nxt = 1'b1; end
                S_IDLE:      begin w_dir_up_nxt = 1'b0; w_dir_down_nxt = 1'b0; end
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_target    <= NF'(1);
            r_dwell_cnt <= '0;
            r_dir_up    <= 1'b0;
            r_dir_down  <= 1'b0;
            r_door_open <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_target    <= w_target_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_dir_down  <= w_dir_down_nxt;
            r_door_open <= w_door_nxt;
            r_fault     <= !w_valid;
        end
    end

    assign bus.target_floor = r_target;
    assign bus.pending      = r_pending;
    assign bus.dir_up       = r_dir_up;
    assign bus.dir_down     = r_dir_down;
    assign bus.door_open    = r_door_open;
    assign bus.fault        = r_fault;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed-vector bench for the LOOK request scheduler with hand-computed expectations.
module tb_elevator_request_scheduler;
    localparam int NF = 4;

    logic clk = 1'b0;
    logic reset;

    elevator_request_scheduler_if #(.NUM_FLOORS(NF)) bus ();

    elevator_request_scheduler #(
        .NUM_FLOORS (NF),
        .DWELL_TICKS(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        step(1);
        bus.tick = 1'b0;
    endtask

    task automatic pulse_call(input logic [NF-1:0] c);
        bus.call_req = c;
        step(1);
        bus.call_req = '0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.call_req = 4'b0100;
        bus.cur_floor = 4'b0001;

        // Reset state, with a call held through reset
        #3;
        chk_vec("rst_pending", 32'(bus.pending), 32'h0);
        chk_vec("rst_target",  32'(bus.target_floor), 32'h1);
        chk_vec("rst_door",    32'(bus.door_open), 32'h0);
        chk_vec("rst_dir",     32'({bus.dir_up, bus.dir_down}), 32'h0);
        chk_vec("rst_fault",   32'(bus.fault), 32'h0);
        step(2);
        reset = 1'b0;
        chk_vec("rel_pending", 32'(bus.pending), 32'h0);
        chk_vec("rel_target",  32'(bus.target_floor), 32'h1);
        step(1);
        chk_vec("latch_pending", 32'(bus.pending), 32'h4);
        bus.call_req = '0;

        // Travel from floor 0 to floor 2 and dwell
        step(1);
        chk_vec("t2_dir_up",   32'(bus.dir_up), 32'h1);
        chk_vec("t2_tgt_hold", 32'(bus.target_floor), 32'h1);
        step(1);
        chk_vec("t2_target",   32'(bus.target_floor), 32'h4);
        bus.cur_floor = 4'b0010;
        step(1);
        chk_vec("t2_pass_tgt", 32'(bus.target_floor), 32'h4);
        chk_vec("t2_pass_door", 32'(bus.door_open), 32'h0);
        bus.cur_floor = 4'b0100;
        step(1);
        chk_vec("t2_arr_pending", 32'(bus.pending), 32'h0);
        chk_vec("t2_arr_door",    32'(bus.door_open), 32'h1);
        chk_vec("t2_arr_dir",     32'(bus.dir_up), 32'h1);
        tick_once();
        chk_vec("t2_tick1_door", 32'(bus.door_open), 32'h1);
        tick_once();
        chk_vec("t2_tick2_door", 32'(bus.door_open), 32'h0);
        chk_vec("t2_idle_dir",   32'({bus.dir_up, bus.dir_down}), 32'h0);

        // Call for the served floor during dwell restarts the dwell
        pulse_call(4'b0100);
        chk_vec("t4_pending", 32'(bus.pending), 32'h4);
        step(1);
        chk_vec("t4_door_in",  32'(bus.door_open), 32'h1);
        chk_vec("t4_clr",      32'(bus.pending), 32'h0);
        bus.tick     = 1'b1;
        bus.call_req = 4'b0100;
        step(1);
        bus.tick     = 1'b0;
        bus.call_req = '0;
        chk_vec("t4_drop",     32'(bus.pending), 32'h0);
        chk_vec("t4_door_r",   32'(bus.door_open), 32'h1);
        tick_once();
        chk_vec("t4_door_t1",  32'(bus.door_open), 32'h1);
        tick_once();
        chk_vec("t4_door_t2",  32'(bus.door_open), 32'h0);

        // LOOK order: at floor 1 heading up with calls at 3 and 0
        bus.cur_floor = 4'b0010;
        pulse_call(4'b1000);
        pulse_call(4'b0001);
        step(1);
        chk_vec("t3_target",  32'(bus.target_floor), 32'h8);
        chk_vec("t3_pending", 32'(bus.pending), 32'h9);
        chk_vec("t3_dir_up",  32'(bus.dir_up), 32'h1);
        bus.cur_floor = 4'b0100;
        step(1);
        bus.cur_floor = 4'b1000;
        step(1);
        chk_vec("t3_arr_door",    32'(bus.door_open), 32'h1);
        chk_vec("t3_arr_pending", 32'(bus.pending), 32'h1);
        tick_once();
        tick_once();
        chk_vec("t3_rev_dir",  32'({bus.dir_up, bus.dir_down}), 32'h1);
        chk_vec("t3_rev_door", 32'(bus.door_open), 32'h0);
        step(1);
        chk_vec("t3_rev_tgt",  32'(bus.target_floor), 32'h1);

        // New call ahead redirects, then asynchronous reset mid-travel
        pulse_call(4'b0010);
        step(1);
        chk_vec("t6_redirect", 32'(bus.target_floor), 32'h2);
        chk_vec("t6_pending",  32'(bus.pending), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        chk_vec("t6_rst_pending", 32'(bus.pending), 32'h0);
        chk_vec("t6_rst_dir",     32'(bus.dir_down), 32'h0);
        chk_vec("t6_rst_target",  32'(bus.target_floor), 32'h1);
        step(1);
        reset = 1'b0;

        // Invalid cur_floor freezes the scheduler but still latches calls
        bus.cur_floor = 4'b0001;
        pulse_call(4'b1000);
        step(2);
        chk_vec("t5_target_pre", 32'(bus.target_floor), 32'h8);
        bus.cur_floor = 4'b0110;
        bus.call_req  = 4'b0010;
        step(1);
        bus.call_req  = '0;
        chk_vec("t5_fault",     32'(bus.fault), 32'h1);
        chk_vec("t5_tgt_hold",  32'(bus.target_floor), 32'h8);
        chk_vec("t5_latch",     32'(bus.pending), 32'ha);
        step(2);
        chk_vec("t5_fault3",    32'(bus.fault), 32'h1);
        chk_vec("t5_tgt_hold3", 32'(bus.target_floor), 32'h8);
        chk_vec("t5_dir_hold",  32'(bus.dir_up), 32'h1);
        bus.cur_floor = 4'b0010;
        step(1);
        chk_vec("t5_fault_clr", 32'(bus.fault), 32'h0);
        chk_vec("t5_resume",    32'(bus.door_open), 32'h1);
        chk_vec("t5_served",    32'(bus.pending), 32'h8);
        step(1);
        chk_vec("t5_tgt_here",  32'(bus.target_floor), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
